// File: rtl/button_step_conditioner_pkg.sv
// ============================================================================
// Module   : button_step_conditioner_pkg
// Purpose  : Shared FSM state encoding and debounce counter width.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package button_step_conditioner_pkg;

    localparam int CNT_W = 24;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/button_step_conditioner_sync_2ff.sv
// ============================================================================
// Module   : sync_2ff
// Purpose  : Two-flop synchronizer bringing the raw button into the clk domain.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/button_step_conditioner.sv
// ============================================================================
// Module   : button_step_conditioner
// Purpose  : Debounces a push-button and issues one step strobe per press.
//            Define STEP_AUTOREPEAT_EN to add hold-to-repeat stepping.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_step_conditioner
    import button_step_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES      = 1000000,
    parameter int REPEAT_DELAY_CYCLES  = 50000000,
    parameter int REPEAT_PERIOD_CYCLES = 20000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_in,
    output logic       btn_level,
    output logic       step_pulse,
    output logic [7:0] step_count
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             w_btn_sync;
    logic [CNT_W-1:0] w_cnt_inc;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             btn_level_q;
    logic             step_pulse_q;
    logic [7:0]       step_count_q;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (btn_in),
        .q_o   (w_btn_sync)
    );

    assign w_cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

`ifdef STEP_AUTOREPEAT_EN
    localparam logic [31:0] RPT_DELAY_LAST  = 32'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [31:0] RPT_PERIOD_LAST = 32'(REPEAT_PERIOD_CYCLES - 1);

    logic [31:0] rpt_cnt_q;
    logic        rpt_first_q;
    logic [31:0] w_rpt_last;

    // First repeat waits the long delay, later ones the shorter period
    assign w_rpt_last = rpt_first_q ? RPT_DELAY_LAST : RPT_PERIOD_LAST;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            btn_level_q  <= 1'b0;
            step_pulse_q <= 1'b0;
            step_count_q <= 8'd0;
`ifdef STEP_AUTOREPEAT_EN
            rpt_cnt_q    <= 32'd0;
            rpt_first_q  <= 1'b1;
`endif
        end else begin
            step_pulse_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (w_btn_sync) begin
                        state_q <= PRESS_WAIT;
                        cnt_q   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    // A drop on the terminal count cancels the press
                    if (!w_btn_sync) begin
                        state_q <= IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q      <= PRESSED;
                        btn_level_q  <= 1'b1;
                        step_pulse_q <= 1'b1;
                        step_count_q <= step_count_q + 8'd1;
`ifdef STEP_AUTOREPEAT_EN
                        rpt_cnt_q    <= 32'd0;
                        rpt_first_q  <= 1'b1;
`endif
                    end else begin
                        cnt_q <= w_cnt_inc;
                    end
                end
                PRESSED: begin
                    if (!w_btn_sync) begin
                        state_q <= RELEASE_WAIT;
                        cnt_q   <= '0;
                    end
`ifdef STEP_AUTOREPEAT_EN
                    else if (rpt_cnt_q == w_rpt_last) begin
                        step_pulse_q <= 1'b1;
                        step_count_q <= step_count_q + 8'd1;
                        rpt_cnt_q    <= 32'd0;
                        rpt_first_q  <= 1'b0;
                    end else begin
                        rpt_cnt_q <= rpt_cnt_q + 32'd1;
                    end
`endif
                end
                RELEASE_WAIT: begin
                    if (w_btn_sync) begin
                        state_q <= PRESSED;
`ifdef STEP_AUTOREPEAT_EN
                        rpt_cnt_q   <= 32'd0;
                        rpt_first_q <= 1'b1;
`endif
                    end else if (cnt_q == CNT_LAST) begin
                        state_q     <= IDLE;
                        btn_level_q <= 1'b0;
                    end else begin
                        cnt_q <= w_cnt_inc;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign btn_level  = btn_level_q;
    assign step_pulse = step_pulse_q;
    assign step_count = step_count_q;

endmodule

`default_nettype wire

// File: tb/tb_button_step_conditioner.sv
// ============================================================================
// Module   : tb_button_step_conditioner
// Purpose  : Scoreboard bench: debounce reference model versus DUT strobes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_button_step_conditioner;

    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RP  = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_in = 1'b0;
    logic       btn_level;
    logic       step_pulse;
    logic [7:0] step_count;

    button_step_conditioner #(
        .DEBOUNCE_CYCLES      (DEB),
        .REPEAT_DELAY_CYCLES  (RD),
        .REPEAT_PERIOD_CYCLES (RP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_in     (btn_in),
        .btn_level  (btn_level),
        .step_pulse (step_pulse),
        .step_count (step_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] cnt;
    } ev_t;

    ev_t  exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   n_pulses = 0;
    int   last_pulse_cyc = -1;
    int   level_fall_cyc = -1;

    // Reference model state
    logic       m1 = 1'b0, m2 = 1'b0, ms = 1'b0, mlvl = 1'b0;
    int         run = 0;
    logic [7:0] mcount = 8'd0;
    int         since = 0;
    bit         first = 1'b1, reent = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_pulse();
        ev_t e;
        mcount = mcount + 8'd1;
        e.cyc  = cyc;
        e.cnt  = mcount;
        exp_q.push_back(e);
    endtask

    // Model: a level is accepted once DEB+1 consecutive synchronized samples
    // disagree with the current level; input reaches the decision 2 edges late.
    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m1 = 0; m2 = 0; mlvl = 0; run = 0; mcount = 0;
                since = 0; first = 1; reent = 0;
                exp_q.delete();
            end else begin
                bit pressed_now;
                cyc++;
                ms = m2;
                m2 = m1;
                m1 = btn_in;
                pressed_now = 1'b0;
                if (ms != mlvl) run++;
                else            run = 0;
                if (run == DEB + 1) begin
                    mlvl = ms;
                    run  = 0;
                    if (ms) begin
                        push_pulse();
                        pressed_now = 1'b1;
                    end
                end
`ifdef STEP_AUTOREPEAT_EN
                if (pressed_now) begin
                    since = 0; first = 1; reent = 0;
                end else if (mlvl) begin
                    if (!ms) begin
                        since = 0; first = 1; reent = 1;
                    end else if (reent) begin
                        since = 0; reent = 0;
                    end else begin
                        since++;
                        if (since == (first ? RD : RP)) begin
                            push_pulse();
                            since = 0;
                            first = 0;
                        end
                    end
                end
`endif
            end
        end
    end

    // Monitor / scoreboard
    logic prev_level = 1'b0;
    always @(negedge clk) begin
        check("btn_level", int'(btn_level), int'(mlvl));
        check("step_count", int'(step_count), int'(mcount));
        if (prev_level && !btn_level) level_fall_cyc = cyc;
        prev_level = btn_level;
        if (step_pulse) begin
            n_pulses++;
            last_pulse_cyc = cyc;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: got pulse at cycle %0d expected none", cyc);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_count", int'(step_count), int'(e.cnt));
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL missing_pulse: got none at cycle %0d expected pulse", exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
    end

    task automatic drive(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            btn_in = v;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        btn_in = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst_level", int'(btn_level), 0);
        check("rst_pulse", int'(step_pulse), 0);
        check("rst_count", int'(step_count), 0);
        @(negedge clk);
        #2 reset = 1'b0;
    endtask

    initial begin
        int p0, s0, d1;

        // Clean press
        do_reset();
        p0 = n_pulses;
        @(negedge clk); btn_in = 1'b1; s0 = cyc + 1;
        repeat (20) @(negedge clk);
        check("clean_pulses", n_pulses - p0, 1);
        check("clean_latency", last_pulse_cyc - s0, DEB + 2);
        check("clean_level", int'(btn_level), 1);
        check("clean_count", int'(step_count), 1);

        // Press bounce
        do_reset();
        p0 = n_pulses;
        drive(1'b1, 2);
        drive(1'b0, 1);
        @(negedge clk); btn_in = 1'b1; s0 = cyc + 1;
        repeat (15) @(negedge clk);
        check("bounce_pulses", n_pulses - p0, 1);
        check("bounce_latency", last_pulse_cyc - s0, DEB + 2);
        check("bounce_count", int'(step_count), 1);

        // Release bounce
        p0 = n_pulses;
        drive(1'b0, 2);
        drive(1'b1, 1);
        @(negedge clk); btn_in = 1'b0; s0 = cyc + 1;
        repeat (12) @(negedge clk);
        check("relbounce_pulses", n_pulses - p0, 0);
        check("relbounce_fall", level_fall_cyc - s0, DEB + 2);
        check("relbounce_level", int'(btn_level), 0);

        // Drop on the terminal count beats the press; one more sample wins
        do_reset();
        p0 = n_pulses;
        drive(1'b1, DEB);
        drive(1'b0, 10);
        check("dropwin_pulses", n_pulses - p0, 0);
        drive(1'b1, DEB + 1);
        drive(1'b0, 12);
        check("justenough_pulses", n_pulses - p0, 1);

        // Reset while debouncing with button still held
        do_reset();
        p0 = n_pulses;
        @(negedge clk); btn_in = 1'b1;
        repeat (5) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_level", int'(btn_level), 0);
        check("midrst_pulse", int'(step_pulse), 0);
        check("midrst_count", int'(step_count), 0);
        @(negedge clk);
        #2 reset = 1'b0;
        d1 = cyc + 1;
        repeat (12) @(negedge clk);
        check("midrst_pulses", n_pulses - p0, 1);
        check("midrst_latency", last_pulse_cyc - d1, DEB + 2);
        drive(1'b0, 10);

        // Counter wrap
        do_reset();
        p0 = n_pulses;
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 7);
            drive(1'b0, 9);
        end
        check("wrap_pulses", n_pulses - p0, 256);
        check("wrap_count", int'(step_count), 0);

        // Long hold
        do_reset();
        p0 = n_pulses;
        drive(1'b1, 37);
        drive(1'b0, 15);
`ifdef STEP_AUTOREPEAT_EN
        check("hold_pulses", n_pulses - p0, 6);
`else
        check("hold_pulses", n_pulses - p0, 1);
`endif

        // Random bouncy traffic against the model
        do_reset();
        for (int t = 0; t < 1500; ) begin
            int len;
            logic v;
            v   = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 8));
            drive(v, len);
            t += len;
        end
        drive(1'b0, 20);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
